// File: rtl/serial_adder_if.sv
// Request/result bundle for the bit-serial adder: operands and start in, sum/carry and status out.
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
   );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder slice per clock, LSB first, result with a done pulse.
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst,
   serial_adder_if.slave  bus
);
   localparam int               CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] areg_q, areg_d;
   logic [WIDTH-1:0] breg_q, breg_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             s_bit, c_bit;

   // NOTE: every register has a reset value here; none of this is a memory array, so clearing it is free.
   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         areg_q  <= '0;
         breg_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         areg_q  <= areg_d;
         breg_q  <= breg_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign s_bit = areg_q[0] ^ breg_q[0] ^ carry_q;
   assign c_bit = (areg_q[0] & breg_q[0]) | (carry_q & (areg_q[0] ^ breg_q[0]));

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      areg_d  = areg_q;
      breg_d  = breg_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               areg_d  = bus.a;
               breg_d  = bus.b;
               carry_d = bus.cin;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // Sum bits enter the MSB as operand A drains out, so areg doubles as the sum shifter.
            areg_d  = {s_bit, areg_q[WIDTH-1:1]};
            breg_d  = {1'b0, breg_q[WIDTH-1:1]};
            carry_d = c_bit;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               sum_d   = areg_d;
               cout_d  = c_bit;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.busy = (state_q == SHIFT);
   assign bus.done = (state_q == DONE);
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: an 8-bit instance for directed/random adds, a 4-bit one swept exhaustively.
module tb_serial_adder_ctrl;
   localparam int W  = 8;
   localparam int W4 = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   serial_adder_if #(.WIDTH(W))  bus8 ();
   serial_adder_if #(.WIDTH(W4)) bus4 ();

   serial_adder_ctrl #(.WIDTH(W))  dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
   serial_adder_ctrl #(.WIDTH(W4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

   int errors = 0;
   int checks = 0;

   logic [W:0]  sb8 [$];
   logic [W4:0] sb4 [$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One add on the 8-bit unit. poke_cycle>0 pulses a stray start with poke_a during that cycle.
   task automatic run8(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input int poke_cycle, input logic [W-1:0] poke_a);
      logic [W:0] prev, got, exp;
      int  pulses, lat;
      bit  excl_bad, busy_bad, hold_bad;
      prev     = {bus8.cout, bus8.sum};
      pulses   = 0;
      lat      = 0;
      got      = '0;
      excl_bad = 0;
      busy_bad = 0;
      hold_bad = 0;
      bus8.a     = a;
      bus8.b     = b;
      bus8.cin   = cin;
      bus8.start = 1'b1;
      sb8.push_back((W+1)'(a) + (W+1)'(b) + (W+1)'(cin));
      tick();
      bus8.start = 1'b0;
      bus8.a     = W'($urandom);
      bus8.b     = W'($urandom);
      bus8.cin   = 1'($urandom);
      for (int cyc = 1; cyc <= W + 4; cyc++) begin
         if (cyc == poke_cycle) begin
            bus8.start = 1'b1;
            bus8.a     = poke_a;
            bus8.b     = 8'h22;
         end else begin
            bus8.start = 1'b0;
         end
         if (bus8.busy && bus8.done) excl_bad = 1;
         if (bus8.done) begin
            pulses++;
            if (lat == 0) begin
               lat = cyc;
               got = {bus8.cout, bus8.sum};
            end
         end else if (lat == 0) begin
            if (!bus8.busy) busy_bad = 1;
            if ({bus8.cout, bus8.sum} !== prev) hold_bad = 1;
         end else if ({bus8.cout, bus8.sum} !== got) begin
            hold_bad = 1;
         end
         tick();
      end
      bus8.start = 1'b0;
      exp = sb8.pop_front();

      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL %s done_pulses: got %0d want 1", name, pulses);
      end
      checks++;
      if (lat != W + 1) begin
         errors++;
         $display("FAIL %s latency: got %0d want %0d", name, lat, W + 1);
      end
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s result {cout,sum}: got %h want %h", name, got, exp);
      end
      checks++;
      if (excl_bad || busy_bad) begin
         errors++;
         $display("FAIL %s busy/done: got excl_bad=%0d busy_bad=%0d want 0/0", name, excl_bad, busy_bad);
      end
      checks++;
      if (hold_bad) begin
         errors++;
         $display("FAIL %s sum_hold: got changed outside done want held", name);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({bus8.busy, bus8.done, bus8.cout, bus8.sum} !== {3'b000, 8'h00}) begin
         errors++;
         $display("FAIL reset8: got busy=%b done=%b cout=%b sum=%h want 0 0 0 00",
                  bus8.busy, bus8.done, bus8.cout, bus8.sum);
      end
      checks++;
      if ({bus4.busy, bus4.done, bus4.cout, bus4.sum} !== {3'b000, 4'h0}) begin
         errors++;
         $display("FAIL reset4: got busy=%b done=%b cout=%b sum=%h want 0 0 0 0",
                  bus4.busy, bus4.done, bus4.cout, bus4.sum);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      run8("basic_05_03", 8'h05, 8'h03, 1'b0, 0, 8'h00);
   endtask

   task automatic test_wrap();
      run8("wrap_ff_01", 8'hFF, 8'h01, 1'b0, 0, 8'h00);
      run8("wrap_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 0, 8'h00);
   endtask

   task automatic test_start_while_busy();
      run8("start_busy", 8'h12, 8'h34, 1'b0, 3, 8'h11);
   endtask

   task automatic test_reset_mid_op();
      int pulses;
      bus8.a     = 8'h5A;
      bus8.b     = 8'hC3;
      bus8.cin   = 1'b1;
      bus8.start = 1'b1;
      tick();
      bus8.start = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({bus8.busy, bus8.done, bus8.cout, bus8.sum} !== {3'b000, 8'h00}) begin
         errors++;
         $display("FAIL reset_mid: got busy=%b done=%b cout=%b sum=%h want 0 0 0 00",
                  bus8.busy, bus8.done, bus8.cout, bus8.sum);
      end
      pulses = 0;
      for (int cyc = 0; cyc < W + 4; cyc++) begin
         if (bus8.done || bus8.busy) pulses++;
         tick();
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL reset_mid_quiet: got %0d busy/done cycles want 0", pulses);
      end
      run8("after_reset_80_80", 8'h80, 8'h80, 1'b0, 0, 8'h00);
   endtask

   task automatic test_random();
      for (int i = 0; i < 16; i++) begin
         run8("random", W'($urandom), W'($urandom), 1'($urandom), 0, 8'h00);
      end
   endtask

   task automatic test_exhaustive4();
      logic [W4:0] exp;
      bit          seen;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            for (int c = 0; c < 2; c++) begin
               bus4.a     = W4'(a);
               bus4.b     = W4'(b);
               bus4.cin   = 1'(c);
               bus4.start = 1'b1;
               sb4.push_back((W4+1)'(a) + (W4+1)'(b) + (W4+1)'(c));
               tick();
               bus4.start = 1'b0;
               seen = 0;
               for (int k = 0; k < W4 + 4 && !seen; k++) begin
                  if (bus4.done) seen = 1;
                  else tick();
               end
               exp = sb4.pop_front();
               checks++;
               if (!seen) begin
                  errors++;
                  $display("FAIL exh4 timeout a=%0d b=%0d cin=%0d: got no done want done", a, b, c);
               end else if ({bus4.cout, bus4.sum} !== exp) begin
                  errors++;
                  $display("FAIL exh4 a=%0d b=%0d cin=%0d: got %h want %h",
                           a, b, c, {bus4.cout, bus4.sum}, exp);
               end
               tick();
            end
         end
      end
   endtask

   initial begin
      bus8.start = 1'b0;
      bus8.a     = '0;
      bus8.b     = '0;
      bus8.cin   = 1'b0;
      bus4.start = 1'b0;
      bus4.a     = '0;
      bus4.b     = '0;
      bus4.cin   = 1'b0;
      test_reset();
      test_basic();
      test_wrap();
      test_start_while_busy();
      test_reset_mid_op();
      test_random();
      test_exhaustive4();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
